// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller.
// Owns the fetch address, reads a combinational ROM, buffers the returned
// words in a small circular queue and hands them to decode over valid/ready.
// Handles redirects (flush + refetch), a debug halt, and a fetch counter.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] fetch_count,
    output logic        halted
);

    localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [31:0]     fetch_pc_reg;
    logic [31:0]     fetch_count_reg;
    logic [AW:0]     count_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic            halted_reg;
    logic            push;
    logic            pop;

    // Queue storage: one PC and one instruction word per slot.
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    // The ROM always sees the current fetch address, whatever the state.
    assign rom_addr    = fetch_pc_reg;
    assign fetch_count = fetch_count_reg;
    assign halted      = halted_reg;

    // Head is masked during a redirect cycle so a stale word is never taken.
    assign inst_valid  = (count_reg != '0) && !redirect;
    assign inst_data   = data_mem[rd_ptr_reg];
    assign inst_pc     = pc_mem[rd_ptr_reg];
    assign pop         = inst_valid && inst_ready;

    // Next state and push decision; redirect never alters the state.
    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        unique case (state_reg)
            BOOT: state_next = halt ? HALT : RUN;
            RUN: begin
                state_next = halt ? HALT : RUN;
                push       = !halt && !redirect && ((count_reg < DEPTH_CNT) || pop);
            end
            HALT: state_next = halt ? HALT : RUN;
            default: state_next = BOOT;
        endcase
    end

    // State, halted flag, fetch address, counters and queue pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= BOOT;
            halted_reg      <= 1'b0;
            fetch_pc_reg    <= RESET_PC;
            fetch_count_reg <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= (state_next == HALT);
            if (redirect) begin
                // Flush wins over any simultaneous push or pop.
                fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
                count_reg    <= '0;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
            end else begin
                if (push) begin
                    fetch_pc_reg    <= fetch_pc_reg + 32'd4;
                    fetch_count_reg <= fetch_count_reg + 32'd1;
                    wr_ptr_reg      <= wr_ptr_reg + AW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                unique case ({push, pop})
                    2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                    2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Queue slot write; contents need no reset because count guards them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= fetch_pc_reg;
            data_mem[wr_ptr_reg] <= rom_data;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller between the PC logic and the combinational instruction ROM. It owns the fetch address and drives the ROM each cycle. It captures returned words into a small instruction queue and presents them to decode over a valid/ready handshake. It also handles branch/jump redirects from execute (flush and refetch), a debug halt, and a free-running fetch counter.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2: instruction queue entries; power of 2, ≥2.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rom_addr  out  32  byte address to ROM (ROM indexes addr[31:2]); equals fetch_pc.
- rom_data  in  32  ROM word for rom_addr, same cycle (combinational).
- redirect  in  1  taken branch/jump from execute; flushes queue.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- halt  in  1  level; stop issuing new fetches while high.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  head instruction address.
- fetch_count  out  32  number of words pushed into queue since reset; wraps.
- halted  out  1  high in HALT state.

## Operation
- FSM states: BOOT, RUN, HALT.
  - BOOT: entered on reset; no push; next edge -> RUN (or HALT if halt=1).
  - RUN: push when allowed (below); halt=1 at an edge -> HALT (no push that edge).
  - HALT: no push; halt=0 -> RUN. Queue keeps draining to decode.
  - Redirect is honoured in every state; it does not change state.
- Push condition (RUN only): !redirect && (count<DEPTH || pop). Push stores {fetch_pc, rom_data} at tail, fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), fetch_count += 1 (wraps).
- Pop: inst_valid && inst_ready. Head advances.
- inst_valid = (count!=0) && !redirect. Combinational mask so no stale word is accepted in a redirect cycle.
- Redirect at an edge:
  - queue count -> 0; fetch_pc <= {redirect_pc[31:2],2'b00};
  - no push, no pop, fetch_count unchanged.
  - Redirect has priority over every simultaneous event.
- Full (count==DEPTH) with simultaneous pop: push and pop both occur; count unchanged.
- Empty: no pop possible; inst_data/inst_pc undefined-but-stable (hold last head slot).
- rom_addr = fetch_pc in all states, including HALT/BOOT (ROM read is side-effect free).
- Queue: circular buffer, rd/wr pointers log2(DEPTH) bits, count log2(DEPTH)+1 bits.

## Timing
- Reset values (async, immediate on reset=0):
  - state=BOOT; fetch_pc=RESET_PC; rom_addr=RESET_PC.
  - count=0, pointers=0; inst_valid=0.
  - fetch_count=0; halted=0.
- Reset asserted mid-operation: everything returns to reset values at once; in-flight queue contents are lost.
- After reset release:
  - edge 1: BOOT->RUN.
  - edge 2: first push (RESET_PC).
  - inst_valid=1 after edge 2.
- Throughput: 1 instruction/cycle sustained with inst_ready=1.
- Fetch-to-valid latency: 1 edge (push edge) when queue was empty.
- Redirect latency: redirect high before edge N.
  - Edge N: flush.
  - Edge N+1: push of redirect_pc.
  - inst_valid with inst_pc=redirect_pc after N+1.
- halt seen at edge N: last push at edge N-1; halted=1 after N. Release at edge M: first new push at M+1.
- halted is a registered output.

## Test plan
- Reset, ROM word[k]=k, inst_ready=1 -> inst_valid rises after edge 2. inst_pc sequence 0,4,8,…, inst_data 0,1,2,…. fetch_count increments by 1/cycle.
- inst_ready=0 for 5 cycles -> exactly DEPTH=2 pushes (pc 0,4). fetch_pc holds 8, fetch_count=2. Release ready -> pc 0,4,8 in order, no gaps or duplicates.
- Queue full plus redirect_pc=32'h20 (with bits [1:0]=2'b11) -> inst_valid=0 in redirect cycle. Next valid inst_pc=32'h20, data=word[8]. Old entries never appear.
- Redirect while inst_ready=1 and queue non-empty -> no handshake in that cycle. fetch_count unchanged on redirect edge.
- halt=1 for 4 cycles while running -> halted=1 from next cycle. Queue drains to empty. No new fetch_count increments. Release -> fetching resumes at saved fetch_pc.
- RESET_PC=32'hFFFF_FFF8, run -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert reset mid-stream -> inst_valid=0, fetch_count=0 immediately without a clock edge.
